// File: rtl/sprite_renderer.sv
// sprite_renderer: hardware sprite engine for a raster display.
// During horizontal blank each sprite's bitmap row for the upcoming line is
// fetched into a per-sprite line buffer; during the line, per-sprite column
// counters walk those buffers and the lowest-index opaque sprite wins the
// pixel. Sprite attributes are double-buffered so motion only happens
// between frames.
//
// Build option: define SPRITE_MIRROR_EN for 16-px wide sprites mirrored about
// their centre; left undefined, sprites are 8 px wide and unmirrored.
//
// Protocol: wr_en is a single-cycle write strobe with no backpressure -- the
// shadow write completes in the cycle wr_en is high. line_start and
// frame_start are single-cycle pulses from the sync generator. rom_bits must
// answer rom_addr combinationally within the same cycle.
module sprite_renderer #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 11,
  localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int ROM_AW     = $clog2(NUM_SPRITES) + 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               display_on,
  input  logic               line_start,
  input  logic               frame_start,
  input  logic               wr_en,
  input  logic [SEL_W-1:0]   wr_sel,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [2:0]         wr_color,
  input  logic               wr_visible,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [7:0]         rom_bits,
  output logic               red,
  output logic               green,
  output logic               blue,
  output logic               collision,
  input  logic               clr_collision
);

`ifdef SPRITE_MIRROR_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 3;
`endif
  // Counter reload value: sprite width minus one.
  localparam logic [CNT_W-1:0] SPAN_M1 = {CNT_W{1'b1}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_t;

  // Fetch state is kept as a named enum so checkers can bind to it directly.
  fetch_state_t     fetch_state;
  logic [SEL_W-1:0] fetch_idx;

  // Shadow (CPU-written) and live (frame-stable) sprite attributes.
  logic [COORD_W-1:0] sh_x     [NUM_SPRITES];
  logic [COORD_W-1:0] sh_y     [NUM_SPRITES];
  logic [2:0]         sh_color [NUM_SPRITES];
  logic               sh_vis   [NUM_SPRITES];
  logic [COORD_W-1:0] lv_x     [NUM_SPRITES];
  logic [COORD_W-1:0] lv_y     [NUM_SPRITES];
  logic [2:0]         lv_color [NUM_SPRITES];
  logic               lv_vis   [NUM_SPRITES];

  // Per-sprite bitmap row for the current line and column walkers.
  logic [7:0]       line_buf [NUM_SPRITES];
  logic [CNT_W-1:0] col_cnt  [NUM_SPRITES];
  logic             col_act  [NUM_SPRITES];

  // Fetch-side row arithmetic for the sprite selected by fetch_idx.
  logic [COORD_W-1:0] next_line;
  logic [COORD_W-1:0] cur_y;
  logic               cur_vis;
  logic [COORD_W-1:0] row_diff;
  logic               row_hit;
  logic [3:0]         row_sel;

  // Pixel-side compositing.
  logic [2:0] bit_sel [NUM_SPRITES];
  logic       opaque  [NUM_SPRITES];
  logic [2:0] pix_color;
  logic       pix_any;
  logic       pix_multi;

  // Shadow writes from the CPU port; whole shadow set copied to live at frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x[i]     <= '0;
        sh_y[i]     <= '0;
        sh_color[i] <= 3'b111;
        sh_vis[i]   <= 1'b0;
        lv_x[i]     <= '0;
        lv_y[i]     <= '0;
        lv_color[i] <= 3'b111;
        lv_vis[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (wr_en && (wr_sel == SEL_W'(i))) begin
          sh_x[i]     <= wr_x;
          sh_y[i]     <= wr_y;
          sh_color[i] <= wr_color;
          sh_vis[i]   <= wr_visible;
        end
        if (frame_start) begin
          lv_x[i]     <= sh_x[i];
          lv_y[i]     <= sh_y[i];
          lv_color[i] <= sh_color[i];
          lv_vis[i]   <= sh_vis[i];
        end
      end
    end
  end

  // Row lookup for the sprite being fetched; rejects rows that would only
  // match by wrapping past the last line back into line 0.
  always_comb begin
    cur_y   = lv_y[0];
    cur_vis = lv_vis[0];
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (fetch_idx == SEL_W'(i)) begin
        cur_y   = lv_y[i];
        cur_vis = lv_vis[i];
      end
    end
    next_line = vpos + COORD_W'(1);
    row_diff  = next_line - cur_y;
    row_hit   = cur_vis && (next_line >= cur_y) && (row_diff < COORD_W'(16));
    row_sel   = row_diff[3:0];
  end

  generate
    if (NUM_SPRITES > 1) begin : g_addr_idx
      assign rom_addr = {fetch_idx, row_sel};
    end else begin : g_addr_row
      assign rom_addr = row_sel;
    end
  endgenerate

  // Fetch FSM: one sprite row per cycle into its line buffer after line_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_state <= S_IDLE;
      fetch_idx   <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) line_buf[i] <= 8'h00;
    end else if (line_start) begin
      fetch_state <= S_FETCH;
      fetch_idx   <= '0;
    end else if (fetch_state == S_FETCH) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (fetch_idx == SEL_W'(i)) line_buf[i] <= row_hit ? rom_bits : 8'h00;
      end
      if (fetch_idx == SEL_W'(NUM_SPRITES - 1)) begin
        fetch_state <= S_IDLE;
        fetch_idx   <= '0;
      end else begin
        fetch_idx <= fetch_idx + SEL_W'(1);
      end
    end
  end

  // Column walkers: arm at hpos == x, count down to 0, then go inactive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        col_cnt[i] <= '0;
        col_act[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (hpos == lv_x[i]) begin
          col_cnt[i] <= SPAN_M1;
          col_act[i] <= 1'b1;
        end else if (col_act[i]) begin
          if (col_cnt[i] == '0) col_act[i] <= 1'b0;
          else                  col_cnt[i] <= col_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Per-sprite opacity and lowest-index-wins colour selection.
  always_comb begin
    pix_color = 3'b000;
    pix_any   = 1'b0;
    pix_multi = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      bit_sel[i] = col_cnt[i][2:0];
`ifdef SPRITE_MIRROR_EN
      // Upper half of the span reads the row backwards: bit 15-counter.
      if (col_cnt[i][3]) bit_sel[i] = ~col_cnt[i][2:0];
`endif
      opaque[i] = col_act[i] & line_buf[i][bit_sel[i]];
      if (opaque[i]) begin
        if (pix_any) begin
          pix_multi = 1'b1;
        end else begin
          pix_color = lv_color[i];
          pix_any   = 1'b1;
        end
      end
    end
  end

  // Registered RGB (blanked outside active video) and sticky collision flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red       <= 1'b0;
      green     <= 1'b0;
      blue      <= 1'b0;
      collision <= 1'b0;
    end else begin
      {red, green, blue} <= display_on ? pix_color : 3'b000;
      if (display_on && pix_multi) collision <= 1'b1;
      else if (clr_collision)      collision <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: directed scenarios for sprite_renderer. Drivers push
// the hand-derived expected {collision, r, g, b} per issued pixel; a monitor
// pops and compares one cycle later when the registered output is present.
`timescale 1ns/1ps
module tb_sprite_renderer;
  localparam int N      = 4;
  localparam int CW     = 11;
  localparam int SW     = 2;
  localparam int AW     = 6;
  localparam int IDLE_H = 2000;

  // Column masks (MSB = leftmost column of the span), derived by hand per build.
`ifdef SPRITE_MIRROR_EN
  localparam logic [15:0] P_CC = 16'b0011001111001100;
  localparam logic [15:0] P_FF = 16'hFFFF;
  localparam logic [15:0] P_03 = 16'b1100000000000011;
  localparam logic [15:0] P_81 = 16'b1000000110000001;
  localparam int FIRST_HIT = 131;
`else
  localparam logic [15:0] P_CC = 16'b1100110000000000;
  localparam logic [15:0] P_FF = 16'hFF00;
  localparam logic [15:0] P_03 = 16'b0000001100000000;
  localparam logic [15:0] P_81 = 16'b1000000100000000;
  localparam int FIRST_HIT = 129;
`endif

  logic          clk;
  logic          reset;
  logic [CW-1:0] hpos, vpos;
  logic          display_on, line_start, frame_start;
  logic          wr_en;
  logic [SW-1:0] wr_sel;
  logic [CW-1:0] wr_x, wr_y;
  logic [2:0]    wr_color;
  logic          wr_visible;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_bits;
  logic          red, green, blue, collision, clr_collision;

  logic [7:0] rom_tab [64];
  always_comb rom_bits = rom_tab[rom_addr];

  // Scoreboard state
  logic [3:0] exp_q [$];
  int         exp_hq [$];
  logic       px_issue;
  logic       issue_d;
  int         n_checks;
  int         n_pass;
  string      cur_tag;
  logic [3:0] got_v, exp_v;
  int         got_h;

  // Expected picture for the line about to be scanned
  logic [2:0] exp_rgb [2048];
  logic       exp_hit [2048];
  logic       painted [2048];
  logic       ec;

  sprite_renderer #(.NUM_SPRITES(N), .COORD_W(CW)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .line_start(line_start), .frame_start(frame_start),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .wr_visible(wr_visible),
    .rom_addr(rom_addr), .rom_bits(rom_bits),
    .red(red), .green(green), .blue(blue),
    .collision(collision), .clr_collision(clr_collision)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ec = 1'b0;
  endtask

  // Monitor: one output sample per issued pixel, one cycle after issue
  always @(posedge clk) issue_d <= px_issue;

  always @(negedge clk) begin
    if (issue_d) begin
      n_checks++;
      got_v = {collision, red, green, blue};
      if (exp_q.size() == 0) begin
        $display("FAIL %s underflow got=%b required=none", cur_tag, got_v);
      end else begin
        exp_v = exp_q.pop_front();
        got_h = exp_hq.pop_front();
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s h=%0d {coll,r,g,b} got=%b required=%b", cur_tag, got_h, got_v, exp_v);
      end
    end
  end

  // Driver tasks
  task automatic wr_sprite(input int sel, input int x, input int y, input logic [2:0] col, input logic vis);
    wr_sel = SW'(sel); wr_x = CW'(x); wr_y = CW'(y); wr_color = col; wr_visible = vis;
    wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic fetch(input int v);
    vpos = CW'(v); hpos = CW'(IDLE_H); display_on = 1'b0;
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    repeat (N + 1) @(posedge clk);
    #1;
  endtask

  function automatic void clear_exp();
    for (int h = 0; h < 2048; h++) begin
      exp_rgb[h] = 3'b000; exp_hit[h] = 1'b0; painted[h] = 1'b0;
    end
  endfunction

  // Call in ascending sprite index so the first painter owns the colour.
  function automatic void paint(input int x, input logic [15:0] cols, input logic [2:0] col);
    for (int c = 0; c < 16; c++) begin
      if (cols[15 - c]) begin
        if (painted[x + 1 + c]) exp_hit[x + 1 + c] = 1'b1;
        else begin
          painted[x + 1 + c] = 1'b1;
          exp_rgb[x + 1 + c] = col;
        end
      end
    end
  endfunction

  task automatic scan(input string tag, input int v, input int h0, input int h1, input logic de, input int clr_at);
    cur_tag = tag;
    vpos = CW'(v);
    for (int h = h0; h <= h1; h++) begin
      hpos = CW'(h); display_on = de; clr_collision = (h == clr_at);
      if (de && exp_hit[h]) ec = 1'b1;
      else if (h == clr_at) ec = 1'b0;
      exp_q.push_back({ec, de ? exp_rgb[h] : 3'b000});
      exp_hq.push_back(h);
      px_issue = 1'b1;
      @(posedge clk); #1;
    end
    px_issue = 1'b0; clr_collision = 1'b0; display_on = 1'b0; hpos = CW'(IDLE_H);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running required=finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    n_checks = 0; n_pass = 0; px_issue = 1'b0; cur_tag = "init";
    hpos = CW'(IDLE_H); vpos = '0; display_on = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    wr_en = 1'b0; wr_sel = '0; wr_x = '0; wr_y = '0; wr_color = 3'b000; wr_visible = 1'b0;
    clr_collision = 1'b0; ec = 1'b0;
    for (int a = 0; a < 64; a++) rom_tab[a] = 8'h00;
    #1;
    apply_reset();

    // Reset state: nothing visible, no collision
    clear_exp();
    scan("reset_state", 0, 0, 3, 1'b1, -1);

    // Single sprite, row 2 = 11001100
    rom_tab[2] = 8'b11001100;
    wr_sprite(0, 128, 128, 3'b111, 1'b1);
    frame_pulse();
    fetch(129);
    clear_exp(); paint(128, P_CC, 3'b111);
    scan("basic_row", 130, 124, 220, 1'b1, -1);

    // Mid-frame move of sprite 1 takes effect only after frame_start
    rom_tab[18] = 8'hFF;
    wr_sprite(1, 160, 128, 3'b001, 1'b1);
    frame_pulse();
    fetch(129);
    clear_exp(); paint(128, P_CC, 3'b111); paint(160, P_FF, 3'b001);
    scan("pre_move", 130, 124, 220, 1'b1, -1);
    wr_sprite(1, 200, 128, 3'b001, 1'b1);
    fetch(129);
    scan("mid_frame_hold", 130, 124, 220, 1'b1, -1);
    frame_pulse();
    fetch(129);
    clear_exp(); paint(128, P_CC, 3'b111); paint(200, P_FF, 3'b001);
    scan("after_frame", 130, 124, 220, 1'b1, -1);

    // Overlap: red beats green, collision sets and is sticky
    rom_tab[18] = 8'b11001100;
    wr_sprite(0, 128, 128, 3'b100, 1'b1);
    wr_sprite(1, 128, 128, 3'b010, 1'b1);
    frame_pulse();
    fetch(129);
    clear_exp(); paint(128, P_CC, 3'b100); paint(128, P_CC, 3'b010);
    scan("overlap_set", 130, 124, 220, 1'b1, -1);
    fetch(129);
    scan("overlap_clr_then_set", 130, 124, 220, 1'b1, 125);
    fetch(129);
    scan("clr_vs_set_same_cycle", 130, 124, 220, 1'b1, FIRST_HIT);

    // Row 00000011 (mirror build: both ends of the 16-px span)
    rom_tab[5] = 8'b00000011;
    wr_sprite(1, 128, 128, 3'b010, 1'b0);
    frame_pulse();
    fetch(132);
    clear_exp(); paint(128, P_03, 3'b100);
    scan("row_03", 133, 124, 220, 1'b1, -1);

    // Bottom-edge sprite: rows 0..7 on lines 2040..2047, no wrap into line 0
    rom_tab[32] = 8'hFF;
    rom_tab[39] = 8'b10000001;
    for (int r = 8; r < 16; r++) rom_tab[32 + r] = 8'hFF;
    wr_sprite(2, 300, 2040, 3'b110, 1'b1);
    frame_pulse();
    fetch(2039);
    clear_exp(); paint(300, P_FF, 3'b110);
    scan("wrap_row0", 2040, 296, 320, 1'b1, -1);
    fetch(2046);
    clear_exp(); paint(300, P_81, 3'b110);
    scan("wrap_row7", 2047, 296, 320, 1'b1, -1);
    fetch(2047);
    clear_exp();
    scan("wrap_line0_blank", 0, 296, 320, 1'b1, -1);
    fetch(6);
    scan("wrap_line7_blank", 7, 296, 320, 1'b1, -1);

    // Blanking: display_on low forces black
    fetch(129);
    clear_exp(); paint(128, P_CC, 3'b100);
    scan("display_off", 130, 124, 220, 1'b0, -1);

    // Reset in the middle of a fetch (index 2) with collision set
    vpos = CW'(129); hpos = CW'(IDLE_H);
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();
    rom_tab[2] = 8'b11001100;
    wr_sprite(0, 128, 128, 3'b111, 1'b1);
    frame_pulse();
    clear_exp();
    scan("post_reset_blank", 130, 124, 220, 1'b1, -1);
    fetch(129);
    clear_exp(); paint(128, P_CC, 3'b111);
    scan("post_reset_refetch", 130, 124, 220, 1'b1, -1);

    // Every pushed expectation must have been consumed
    cur_tag = "drain";
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain leftover got=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
